sha256_msg_padder: RTL and testbench

Upstream feeder for the `sha256` core. Accepts a message as a byte stream with a valid/ready handshake and applies FIPS 180-4 padding: a 0x80 marker, zero fill, and a 64-bit big-endian bit length. It emits the result as a sequence of 512-bit blocks, each presented on a valid/ready port that drives the core's `data` input. Messages of any length from 1 byte up to 2^61−1 bytes are split across as many blocks as needed, including the extra length-only block when the padding does not fit.

---
 rtl/sha256_msg_padder.sv | 149 ++++++++++++++
 tb/tb_sha256_msg_padder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: packs a byte stream into 512-bit blocks and appends
// the 0x80 marker, zero fill and 64-bit big-endian bit length.
module sha256_msg_padder #(
   parameter int LEN_W = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [7:0]   in_data,
   input  logic         in_valid,
   input  logic         in_last,
   output logic         in_ready,
   output logic [511:0] blk_data,
   output logic         blk_valid,
   output logic         blk_first,
   output logic         blk_last,
   input  logic         blk_ready
);

   typedef enum logic [1:0] {FILL, EMIT, TAIL} state_t;

   localparam logic [511:0] MARKER = {8'h80, 504'b0};

   state_t             state, state_n;
   logic [511:0]       blk_buf, buf_n;
   logic [5:0]         pos, pos_n;
   logic [60:0]        cnt, cnt_n;
   logic               first, first_n;
   logic               is_final, final_n;
   logic               need80, need80_n;
   logic               tail, tail_n;
   logic [LEN_W-1:0]   len_q, len_n;

   logic [6:0]         p;
   logic [60:0]        cnt_inc;
   logic [LEN_W-1:0]   len_calc;

   assign p        = {1'b0, pos} + 7'd1;
   assign cnt_inc  = cnt + 61'd1;
   assign len_calc = LEN_W'({cnt_inc, 3'b000});

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= FILL;
         blk_buf  <= '0;
         pos      <= '0;
         cnt      <= '0;
         first    <= 1'b1;
         is_final <= 1'b0;
         need80   <= 1'b0;
         tail     <= 1'b0;
         len_q    <= '0;
      end else begin
         state    <= state_n;
         blk_buf  <= buf_n;
         pos      <= pos_n;
         cnt      <= cnt_n;
         first    <= first_n;
         is_final <= final_n;
         need80   <= need80_n;
         tail     <= tail_n;
         len_q    <= len_n;
      end
   end

   // Bytes land by OR-ing a shifted copy into the buffer; the buffer is always
   // cleared on block hand-off, so unwritten byte slots are guaranteed zero.
   always_comb begin
      state_n   = state;
      buf_n     = blk_buf;
      pos_n     = pos;
      cnt_n     = cnt;
      first_n   = first;
      final_n   = is_final;
      need80_n  = need80;
      tail_n    = tail;
      len_n     = len_q;
      in_ready  = 1'b0;
      blk_valid = 1'b0;
      blk_data  = '0;
      blk_first = first;
      blk_last  = 1'b0;

      case (state)
         FILL: begin
            in_ready = 1'b1;
            if (in_valid) begin
               buf_n = blk_buf | ({in_data, 504'b0} >> {pos, 3'b000});
               pos_n = pos + 6'd1;
               cnt_n = cnt_inc;
               if (in_last) begin
                  len_n   = len_calc;
                  state_n = EMIT;
                  if (p <= 7'd55) begin
                     buf_n = buf_n | (MARKER >> {p[5:0], 3'b000});
                     buf_n[LEN_W-1:0] = len_calc;
                     final_n = 1'b1;
                     tail_n  = 1'b0;
                  end else if (p <= 7'd63) begin
                     buf_n    = buf_n | (MARKER >> {p[5:0], 3'b000});
                     final_n  = 1'b0;
                     tail_n   = 1'b1;
                     need80_n = 1'b0;
                  end else begin
                     final_n  = 1'b0;
                     tail_n   = 1'b1;
                     need80_n = 1'b1;
                  end
               end else if (pos == 6'd63) begin
                  state_n = EMIT;
                  final_n = 1'b0;
                  tail_n  = 1'b0;
               end
            end
         end

         EMIT: begin
            blk_valid = 1'b1;
            blk_data  = blk_buf;
            blk_last  = is_final;
            if (blk_ready) begin
               buf_n   = '0;
               pos_n   = '0;
               first_n = 1'b0;
               if (tail) begin
                  state_n = TAIL;
               end else if (is_final) begin
                  cnt_n   = '0;
                  first_n = 1'b1;
                  state_n = FILL;
               end else begin
                  state_n = FILL;
               end
            end
         end

         // Extra block holding only the length (and the marker if it spilled over)
         TAIL: begin
            buf_n            = need80 ? MARKER : '0;
            buf_n[LEN_W-1:0] = len_q;
            final_n          = 1'b1;
            tail_n           = 1'b0;
            state_n          = EMIT;
         end

         default: state_n = FILL;
      endcase
   end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Directed bench for sha256_msg_padder: hand-computed padded blocks for
// short, boundary-length and multi-block messages plus backpressure and reset.
module tb_sha256_msg_padder;

   logic         clk = 1'b0;
   logic         rst;
   logic [7:0]   in_data;
   logic         in_valid;
   logic         in_last;
   logic         in_ready;
   logic [511:0] blk_data;
   logic         blk_valid;
   logic         blk_first;
   logic         blk_last;
   logic         blk_ready;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   sha256_msg_padder #(.LEN_W(64)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .blk_data  (blk_data),
      .blk_valid (blk_valid),
      .blk_first (blk_first),
      .blk_last  (blk_last),
      .blk_ready (blk_ready)
   );

   task automatic send_byte(input logic [7:0] d, input logic last);
      int guard = 0;
      while (!in_ready && guard < 200) begin
         @(posedge clk); #1;
         guard++;
      end
      if (!in_ready) begin
         n_cmp++; n_fail++;
         $display("[TB] FAIL send_timeout: in_ready got 0 expected 1");
      end
      in_data  = d;
      in_valid = 1'b1;
      in_last  = last;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = 8'h00;
   endtask

   task automatic send_fill(input logic [7:0] d, input int n, input logic last_at_end);
      for (int i = 0; i < n; i++) send_byte(d, last_at_end && (i == n - 1));
   endtask

   // Waits (bounded) for a block, captures it, then consumes it for one edge.
   task automatic get_block(output logic [511:0] d, output logic f, output logic l,
                            output int cycles);
      cycles = 0;
      while (!blk_valid && cycles < 200) begin
         @(posedge clk); #1;
         cycles++;
      end
      d = blk_data;
      f = blk_first;
      l = blk_last;
      if (blk_valid) begin
         blk_ready = 1'b1;
         @(posedge clk); #1;
         blk_ready = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; in_data = '0; in_valid = 0; in_last = 0; blk_ready = 0;
      #12;
      n_cmp++; if (blk_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_in_rst_valid: got %b expected 0", blk_valid); end
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
      n_cmp++; if (blk_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_blk_valid: got %b expected 0", blk_valid); end
      n_cmp++; if (blk_data !== 512'h0) begin n_fail++; $display("[TB] FAIL reset_blk_data: got %h expected 0", blk_data); end
      n_cmp++; if (blk_first !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_blk_first: got %b expected 1", blk_first); end
      n_cmp++; if (blk_last !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_blk_last: got %b expected 0", blk_last); end
   endtask

   task automatic test_abc();
      logic [511:0] d; logic f, l; int c;
      logic [511:0] exp = {32'h61626380, 416'h0, 64'h18};
      send_byte(8'h61, 0); send_byte(8'h62, 0); send_byte(8'h63, 1);
      get_block(d, f, l, c);
      n_cmp++; if (c !== 0) begin n_fail++; $display("[TB] FAIL abc_latency: got %0d expected 0", c); end
      n_cmp++; if (d !== exp) begin n_fail++; $display("[TB] FAIL abc_data: got %h expected %h", d, exp); end
      n_cmp++; if (f !== 1'b1) begin n_fail++; $display("[TB] FAIL abc_first: got %b expected 1", f); end
      n_cmp++; if (l !== 1'b1) begin n_fail++; $display("[TB] FAIL abc_last: got %b expected 1", l); end
   endtask

   task automatic test_hello();
      logic [511:0] d; logic f, l; int c;
      logic [103:0] msg = "Hello, world!";
      logic [511:0] exp = {112'h48656c6c6f2c20776f726c642180, 336'h0, 64'h68};
      for (int i = 0; i < 13; i++) send_byte(msg[103 - 8*i -: 8], i == 12);
      get_block(d, f, l, c);
      n_cmp++; if (d !== exp) begin n_fail++; $display("[TB] FAIL hello_data: got %h expected %h", d, exp); end
      n_cmp++; if (f !== 1'b1) begin n_fail++; $display("[TB] FAIL hello_first: got %b expected 1", f); end
      n_cmp++; if (l !== 1'b1) begin n_fail++; $display("[TB] FAIL hello_last: got %b expected 1", l); end
   endtask

   task automatic test_len55();
      logic [511:0] d; logic f, l; int c;
      logic [511:0] exp = {{55{8'h41}}, 8'h80, 64'h1B8};
      send_fill(8'h41, 55, 1);
      get_block(d, f, l, c);
      n_cmp++; if (d !== exp) begin n_fail++; $display("[TB] FAIL len55_data: got %h expected %h", d, exp); end
      n_cmp++; if (f !== 1'b1) begin n_fail++; $display("[TB] FAIL len55_first: got %b expected 1", f); end
      n_cmp++; if (l !== 1'b1) begin n_fail++; $display("[TB] FAIL len55_last: got %b expected 1", l); end
   endtask

   task automatic test_len56();
      logic [511:0] d; logic f, l; int c;
      logic [511:0] exp1 = {{56{8'h41}}, 8'h80, 56'h0};
      logic [511:0] exp2 = {448'h0, 64'h1C0};
      send_fill(8'h41, 56, 1);
      get_block(d, f, l, c);
      n_cmp++; if (d !== exp1) begin n_fail++; $display("[TB] FAIL len56_b1_data: got %h expected %h", d, exp1); end
      n_cmp++; if (f !== 1'b1) begin n_fail++; $display("[TB] FAIL len56_b1_first: got %b expected 1", f); end
      n_cmp++; if (l !== 1'b0) begin n_fail++; $display("[TB] FAIL len56_b1_last: got %b expected 0", l); end
      get_block(d, f, l, c);
      n_cmp++; if (c !== 1) begin n_fail++; $display("[TB] FAIL len56_tail_latency: got %0d expected 1", c); end
      n_cmp++; if (d !== exp2) begin n_fail++; $display("[TB] FAIL len56_b2_data: got %h expected %h", d, exp2); end
      n_cmp++; if (f !== 1'b0) begin n_fail++; $display("[TB] FAIL len56_b2_first: got %b expected 0", f); end
      n_cmp++; if (l !== 1'b1) begin n_fail++; $display("[TB] FAIL len56_b2_last: got %b expected 1", l); end
   endtask

   task automatic test_len64_then_1();
      logic [511:0] d; logic f, l; int c;
      logic [511:0] exp1;
      logic [511:0] exp2 = {8'h80, 440'h0, 64'h200};
      logic [511:0] exp3 = {8'hAB, 8'h80, 432'h0, 64'h08};
      for (int i = 0; i < 64; i++) exp1[511 - 8*i -: 8] = 8'(i);
      for (int i = 0; i < 64; i++) send_byte(8'(i), i == 63);
      get_block(d, f, l, c);
      n_cmp++; if (c !== 0) begin n_fail++; $display("[TB] FAIL len64_b1_latency: got %0d expected 0", c); end
      n_cmp++; if (d !== exp1) begin n_fail++; $display("[TB] FAIL len64_b1_data: got %h expected %h", d, exp1); end
      n_cmp++; if (f !== 1'b1) begin n_fail++; $display("[TB] FAIL len64_b1_first: got %b expected 1", f); end
      n_cmp++; if (l !== 1'b0) begin n_fail++; $display("[TB] FAIL len64_b1_last: got %b expected 0", l); end
      get_block(d, f, l, c);
      n_cmp++; if (c !== 1) begin n_fail++; $display("[TB] FAIL len64_tail_latency: got %0d expected 1", c); end
      n_cmp++; if (d !== exp2) begin n_fail++; $display("[TB] FAIL len64_b2_data: got %h expected %h", d, exp2); end
      n_cmp++; if (f !== 1'b0) begin n_fail++; $display("[TB] FAIL len64_b2_first: got %b expected 0", f); end
      n_cmp++; if (l !== 1'b1) begin n_fail++; $display("[TB] FAIL len64_b2_last: got %b expected 1", l); end
      send_byte(8'hAB, 1);
      get_block(d, f, l, c);
      n_cmp++; if (d !== exp3) begin n_fail++; $display("[TB] FAIL back_to_back_data: got %h expected %h", d, exp3); end
      n_cmp++; if (f !== 1'b1) begin n_fail++; $display("[TB] FAIL back_to_back_first: got %b expected 1", f); end
      n_cmp++; if (l !== 1'b1) begin n_fail++; $display("[TB] FAIL back_to_back_last: got %b expected 1", l); end
   endtask

   task automatic test_backpressure();
      logic [511:0] d; logic f, l; int c;
      logic [511:0] exp = {32'h61626380, 416'h0, 64'h18};
      send_byte(8'h61, 0); send_byte(8'h62, 0); send_byte(8'h63, 1);
      for (int k = 0; k < 5; k++) begin
         n_cmp++; if (blk_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL hold_valid[%0d]: got %b expected 1", k, blk_valid); end
         n_cmp++; if (blk_data !== exp) begin n_fail++; $display("[TB] FAIL hold_data[%0d]: got %h expected %h", k, blk_data, exp); end
         n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL hold_in_ready[%0d]: got %b expected 0", k, in_ready); end
         n_cmp++; if (blk_last !== 1'b1) begin n_fail++; $display("[TB] FAIL hold_last[%0d]: got %b expected 1", k, blk_last); end
         @(posedge clk); #1;
      end
      get_block(d, f, l, c);
      n_cmp++; if (blk_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL after_consume_valid: got %b expected 0", blk_valid); end
      n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL after_consume_in_ready: got %b expected 1", in_ready); end
   endtask

   task automatic test_reset_mid();
      logic [511:0] d; logic f, l; int c;
      logic [511:0] exp = {32'h61626380, 416'h0, 64'h18};
      send_fill(8'h11, 5, 1);
      #2 rst = 1'b1;
      #1;
      n_cmp++; if (blk_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL async_rst_valid: got %b expected 0", blk_valid); end
      n_cmp++; if (blk_data !== 512'h0) begin n_fail++; $display("[TB] FAIL async_rst_data: got %h expected 0", blk_data); end
      n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL async_rst_in_ready: got %b expected 1", in_ready); end
      @(posedge clk); #1;
      rst = 1'b0;
      send_fill(8'h22, 10, 0);
      #2 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      send_byte(8'h61, 0); send_byte(8'h62, 0); send_byte(8'h63, 1);
      get_block(d, f, l, c);
      n_cmp++; if (d !== exp) begin n_fail++; $display("[TB] FAIL post_rst_data: got %h expected %h", d, exp); end
      n_cmp++; if (f !== 1'b1) begin n_fail++; $display("[TB] FAIL post_rst_first: got %b expected 1", f); end
      n_cmp++; if (l !== 1'b1) begin n_fail++; $display("[TB] FAIL post_rst_last: got %b expected 1", l); end
   endtask

   initial begin
      test_reset();
      test_abc();
      test_hello();
      test_len55();
      test_len56();
      test_len64_then_1();
      test_backpressure();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
